disp_share_arbiter: RTL and testbench

//  Shares the 4-digit time-multiplexed 7-seg display among NUM_REQ sources (counter, status, error code, ...).

---
 rtl/disp_pkg.sv | 13 +
 rtl/disp_share_arbiter_rr_pick.sv | 29 ++
 rtl/disp_share_arbiter.sv | 128 ++++++++++++
 tb/tb_disp_share_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared definitions for the display-sharing arbiter slice.
package disp_pkg;

    localparam int DISP_W     = 16;
    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

endpackage

// File: rtl/disp_share_arbiter_rr_pick.sv
// Round-robin picker: first requester at or after rr_ptr+1 (wrapping) whose
// mask bit is set. Purely combinational.
module rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         mask,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic                       found,
    output logic [$clog2(NUM_REQ)-1:0] winner
);

    localparam int IDX_W = $clog2(NUM_REQ);

    // Scan rr_ptr+1 .. rr_ptr+NUM_REQ, first eligible requester wins
    always_comb begin
        found  = 1'b0;
        winner = rr_ptr;
        for (int k = 1; k <= NUM_REQ; k++) begin
            logic [IDX_W-1:0] sel;
            sel = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && req[sel] && mask[sel]) begin
                found  = 1'b1;
                winner = sel;
            end
        end
    end

endmodule

// File: rtl/disp_share_arbiter.sv
// Shares the 4-digit 7-seg display among NUM_REQ sources with a round-robin
// arbiter and a minimum dwell per owner. All outputs are registered.
// Build option: define DISP_ARB_HOLD_EN to keep the last owner's word on
// disp_data while idle; otherwise disp_data clears to 0000 on entering idle.
module disp_share_arbiter
    import disp_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DWELL   = 50_000_000,
    parameter int CNT_W   = 26
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [DISP_W*NUM_REQ-1:0]    req_data,
    output logic [NUM_REQ-1:0]           grant,
    output logic [$clog2(NUM_REQ)-1:0]   owner,
    output logic [DISP_W-1:0]            disp_data,
    output logic                         disp_valid,
    output logic                         switch_p
);

    localparam int               IDX_W   = $clog2(NUM_REQ);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL - 1);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr, rr_d;
    logic [CNT_W-1:0]    dwell_cnt, cnt_d;
    logic [NUM_REQ-1:0]  grant_d;
    logic [IDX_W-1:0]    owner_d;
    logic [DISP_W-1:0]   data_d;
    logic                valid_d;
    logic                sw_d;

    logic [NUM_REQ-1:0]  pick_mask;
    logic                pick_found;
    logic [IDX_W-1:0]    pick_winner;
    logic                take;

    // Owner is excluded while serving so a hand-over always moves to someone else
    assign pick_mask = (state_q == SERVE) ? ~(NUM_REQ'(1) << owner) : {NUM_REQ{1'b1}};

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req    (req),
        .mask   (pick_mask),
        .rr_ptr (rr_ptr),
        .found  (pick_found),
        .winner (pick_winner)
    );

    // Next-state and next-output decode; release takes priority over dwell expiry
    always_comb begin
        state_d = state_q;
        rr_d    = rr_ptr;
        cnt_d   = dwell_cnt;
        grant_d = grant;
        owner_d = owner;
        data_d  = disp_data;
        valid_d = disp_valid;
        sw_d    = 1'b0;
        take    = 1'b0;

        case (state_q)
            IDLE: begin
                take = pick_found;
            end
            SERVE: begin
                if (!req[owner]) begin
                    if (pick_found) begin
                        take = 1'b1;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        valid_d = 1'b0;
`ifndef DISP_ARB_HOLD_EN
                        data_d  = '0;
`endif
                    end
                end else if (dwell_cnt == CNT_MAX && pick_found) begin
                    take = 1'b1;
                end else begin
                    data_d = req_data[DISP_W*int'(owner) +: DISP_W];
                    if (dwell_cnt != CNT_MAX) begin
                        cnt_d = dwell_cnt + 1'b1;
                    end
                end
            end
            default: ;
        endcase

        if (take) begin
            state_d = SERVE;
            grant_d = NUM_REQ'(1) << pick_winner;
            owner_d = pick_winner;
            rr_d    = pick_winner;
            cnt_d   = '0;
            data_d  = req_data[DISP_W*int'(pick_winner) +: DISP_W];
            valid_d = 1'b1;
            sw_d    = 1'b1;
        end
    end

    // State and output registers; rr_ptr resets to the last index so source 0 wins first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr     <= IDX_W'(NUM_REQ - 1);
            dwell_cnt  <= '0;
            grant      <= '0;
            owner      <= '0;
            disp_data  <= '0;
            disp_valid <= 1'b0;
            switch_p   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr     <= rr_d;
            dwell_cnt  <= cnt_d;
            grant      <= grant_d;
            owner      <= owner_d;
            disp_data  <= data_d;
            disp_valid <= valid_d;
            switch_p   <= sw_d;
        end
    end

endmodule

// File: tb/tb_disp_share_arbiter.sv
// Directed bench for disp_share_arbiter (NUM_REQ=4, DWELL=8) with a
// reference model feeding an expected-result queue.
module tb_disp_share_arbiter;

    localparam int N     = 4;
    localparam int DWELL = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [63:0]   req_data;
    logic [N-1:0]  grant;
    logic [1:0]    owner;
    logic [15:0]   disp_data;
    logic          disp_valid;
    logic          switch_p;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  grant;
        logic [1:0]  owner;
        logic [15:0] data;
        logic        valid;
        logic        sw;
    } exp_t;

    exp_t exp_q[$];

    // reference model state
    bit          m_serve;
    int          m_owner;
    int          m_rr;
    int          m_cnt;
    logic [3:0]  m_grant;
    logic [15:0] m_data;
    logic        m_valid;

    disp_share_arbiter #(
        .NUM_REQ (N),
        .DWELL   (DWELL),
        .CNT_W   (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_data   (req_data),
        .grant      (grant),
        .owner      (owner),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .switch_p   (switch_p)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] word(input int i);
        logic [63:0] d;
        d = req_data;
        return d[16*i +: 16];
    endfunction

    // search order rr+1, rr+2, ... skipping excl
    function automatic bit pick(input logic [3:0] r, input int excl, input int rr, output int w);
        w = 0;
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (rr + k) % N;
            if (r[i] && i != excl) begin
                w = i;
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_serve = 0; m_owner = 0; m_rr = N - 1; m_cnt = 0;
        m_grant = '0; m_data = '0; m_valid = 1'b0;
        exp_q.delete();
    endtask

    // advance the model by one clock using current inputs, push expectation
    task automatic model_step();
        int   w;
        bit   sw;
        exp_t e;
        sw = 0;
        if (!m_serve) begin
            if (pick(req, -1, m_rr, w)) sw = 1;
        end else if (!req[m_owner]) begin
            if (pick(req, m_owner, m_rr, w)) sw = 1;
            else begin
                m_serve = 0; m_grant = '0; m_valid = 1'b0;
`ifndef DISP_ARB_HOLD_EN
                m_data = '0;
`endif
            end
        end else if (m_cnt == DWELL - 1 && pick(req, m_owner, m_rr, w)) begin
            sw = 1;
        end else begin
            m_data = word(m_owner);
            if (m_cnt < DWELL - 1) m_cnt++;
        end
        if (sw) begin
            m_serve = 1; m_owner = w; m_rr = w; m_cnt = 0;
            m_grant = 4'(1 << w); m_data = word(w); m_valid = 1'b1;
        end
        e.grant = m_grant; e.owner = 2'(m_owner); e.data = m_data;
        e.valid = m_valid; e.sw = sw;
        exp_q.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        model_step();
        @(posedge clk);
        #1;
        checks++;
        assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL queue_empty observed=0 expected=1");
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("grant", 32'(grant), 32'(e.grant));
            chk("owner", 32'(owner), 32'(e.owner));
            chk("disp_data", 32'(disp_data), 32'(e.data));
            chk("disp_valid", 32'(disp_valid), 32'(e.valid));
            chk("switch_p", 32'(switch_p), 32'(e.sw));
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_grant"}, 32'(grant), 32'h0);
        chk({tag, "_owner"}, 32'(owner), 32'h0);
        chk({tag, "_data"}, 32'(disp_data), 32'h0);
        chk({tag, "_valid"}, 32'(disp_valid), 32'h0);
        chk({tag, "_switch"}, 32'(switch_p), 32'h0);
    endtask

    initial begin
        rst_n    = 1'b0;
        req      = 4'b0000;
        req_data = {16'hC3C3, 16'hB2B2, 16'hA1A1, 16'h1234};
        model_reset();
        #12;
        chk_reset_outputs("reset");

        // 1: all requesting at reset release, source 0 wins first
        req = 4'b1111;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("t1_grant", 32'(grant), 32'h1);
        chk("t1_switch", 32'(switch_p), 32'h1);

        // 2: lone requester keeps the display well past the dwell time
        req = 4'b0001;
        for (int i = 0; i < 30; i++) step();
        chk("t2_data", 32'(disp_data), 32'h1234);
        // live tracking of the owner's word
        req_data[15:0] = 16'h5678;
        step();
        chk("t2_live", 32'(disp_data), 32'h5678);
        req_data[15:0] = 16'h1234;

        // 5: everyone drops -> idle
        req = 4'b0000;
        step();
        step();
        chk("t5_valid", 32'(disp_valid), 32'h0);

        // 3: two requesters alternate every DWELL cycles, display never released
        req = 4'b1010;
        step();
        chk("t3_first_owner", 32'(owner), 32'h1);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("t3_grant_nonzero", 32'(grant != 4'b0000), 32'h1);
        end

        // 4: owner 2 releases at dwell count 3 while source 0 asks
        req = 4'b0100;
        step();
        chk("t4_owner2", 32'(owner), 32'h2);
        for (int i = 0; i < 3; i++) step();
        req = 4'b0001;
        step();
        chk("t4_grant", 32'(grant), 32'h1);
        chk("t4_switch", 32'(switch_p), 32'h1);
        chk("t4_data", 32'(disp_data), 32'h1234);

        // late arrival after dwell saturated preempts on the next edge
        for (int i = 0; i < 10; i++) step();
        req = 4'b1001;
        step();
        chk("preempt_owner", 32'(owner), 32'h3);

        // 6: asynchronous reset mid-serve
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        model_reset();
        req = 4'b1111;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("t6_owner0", 32'(owner), 32'h0);
        for (int i = 0; i < 12; i++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
